bus_arbiter_id: RTL and testbench

- Shares one memory/peripheral slave port between the CPU instruction bus (read-only) and data bus (read/write).
- Sits between the fetch/memory stages and the system interconnect.
- Generates the per-master WaitReq and data-bus grant that the pipeline hazard logic consumes for stalling.
- Data bus has priority, bounded by an anti-starvation streak counter so fetch always progresses.

---
 rtl/bus_arbiter_id.sv | 171 +++++++++++++++++
 tb/tb_bus_arbiter_id.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_id.sv
// Arbitrates one shared slave port between the instruction bus (read-only) and the data bus (read/write).
// Latency: command on the bus 1 cycle after an IDLE grant; write completes in CMD, read data returns 1 cycle after acceptance.
// Backpressure: slave WaitReq holds the command phase indefinitely; masters see WaitReq = request AND NOT completion.
module bus_arbiter_id #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    // instruction fetch master
    input  logic                  i_IBus_RdEn,
    input  logic [ADDR_W-1:0]     i_IBus_Addr,
    output logic [DATA_W-1:0]     o_IBus_RdData,
    output logic                  o_IBus_WaitReq,
    // data master
    input  logic                  i_DBus_RdEn,
    input  logic                  i_DBus_WrEn,
    input  logic [ADDR_W-1:0]     i_DBus_Addr,
    input  logic [DATA_W-1:0]     i_DBus_WrData,
    input  logic [DATA_W/8-1:0]   i_DBus_ByteEn,
    output logic [DATA_W-1:0]     o_DBus_RdData,
    output logic                  o_DBus_WaitReq,
    output logic                  o_DBus_Gnt,
    // shared slave port
    output logic [ADDR_W-1:0]     o_Bus_Addr,
    output logic                  o_Bus_RdEn,
    output logic                  o_Bus_WrEn,
    output logic [DATA_W-1:0]     o_Bus_WrData,
    output logic [DATA_W/8-1:0]   o_Bus_ByteEn,
    input  logic [DATA_W-1:0]     i_Bus_RdData,
    input  logic                  i_Bus_WaitReq
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_CMD,
        ST_I_CMD,
        ST_D_RSP,
        ST_I_RSP
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                wr_q;
    logic                rden_q;
    logic                wren_q;
    logic                gnt_q;
    logic [3:0]          streak_q;
    logic [3:0]          streak_d;
    logic [DATA_W-1:0]   irdata_q;
    logic [DATA_W-1:0]   drdata_q;

    logic                dreq;
    logic                ireq;
    logic                d_win;
    logic                i_win;
    logic                d_done;
    logic                i_done;

    // IDLE arbitration: data bus wins unless it has already taken MAX_D_STREAK grants in a row over a waiting fetch
    always_comb begin
        dreq     = i_DBus_RdEn | i_DBus_WrEn;
        ireq     = i_IBus_RdEn;
        d_win    = dreq && !(ireq && (streak_q == MAX_S));
        i_win    = ireq && !d_win;
        streak_d = streak_q;
        if (d_win) begin
            if (ireq) begin
                streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
            end else begin
                streak_d = 4'd0;
            end
        end else if (i_win) begin
            streak_d = 4'd0;
        end
    end

    // Transfer FSM: latches the winner's command, drives the shared port only from those registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
            rden_q   <= 1'b0;
            wren_q   <= 1'b0;
            gnt_q    <= 1'b0;
            streak_q <= 4'd0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (d_win) begin
                        state_q  <= ST_D_CMD;
                        addr_q   <= i_DBus_Addr;
                        wdata_q  <= i_DBus_WrData;
                        be_q     <= i_DBus_ByteEn;
                        wr_q     <= i_DBus_WrEn;
                        rden_q   <= ~i_DBus_WrEn;
                        wren_q   <= i_DBus_WrEn;
                        gnt_q    <= 1'b1;
                        streak_q <= streak_d;
                    end else if (i_win) begin
                        state_q  <= ST_I_CMD;
                        addr_q   <= i_IBus_Addr;
                        wdata_q  <= '0;
                        be_q     <= '1;
                        wr_q     <= 1'b0;
                        rden_q   <= 1'b1;
                        wren_q   <= 1'b0;
                        gnt_q    <= 1'b0;
                        streak_q <= streak_d;
                    end
                end
                ST_D_CMD, ST_I_CMD: begin
                    if (!i_Bus_WaitReq) begin
                        rden_q <= 1'b0;
                        wren_q <= 1'b0;
                        if (wr_q) begin
                            state_q <= ST_IDLE;
                            gnt_q   <= 1'b0;
                        end else begin
                            state_q <= (state_q == ST_D_CMD) ? ST_D_RSP : ST_I_RSP;
                        end
                    end
                end
                ST_D_RSP: begin
                    drdata_q <= i_Bus_RdData;
                    gnt_q    <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                ST_I_RSP: begin
                    irdata_q <= i_Bus_RdData;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    rden_q  <= 1'b0;
                    wren_q  <= 1'b0;
                    gnt_q   <= 1'b0;
                end
            endcase
        end
    end

    // Completion and master-facing outputs; read data is passed through in the response cycle
    always_comb begin
        d_done = ((state_q == ST_D_CMD) && wr_q && !i_Bus_WaitReq) || (state_q == ST_D_RSP);
        i_done = (state_q == ST_I_RSP);
        o_IBus_WaitReq = ireq & ~i_done;
        o_DBus_WaitReq = dreq & ~d_done;
        o_IBus_RdData  = (state_q == ST_I_RSP) ? i_Bus_RdData : irdata_q;
        o_DBus_RdData  = (state_q == ST_D_RSP) ? i_Bus_RdData : drdata_q;
    end

    assign o_DBus_Gnt   = gnt_q;
    assign o_Bus_Addr   = addr_q;
    assign o_Bus_RdEn   = rden_q;
    assign o_Bus_WrEn   = wren_q;
    assign o_Bus_WrData = wdata_q;
    assign o_Bus_ByteEn = be_q;

endmodule

// File: tb/tb_bus_arbiter_id.sv
// Testbench for bus_arbiter_id: directed scenarios followed by randomized traffic.
// Every cycle is compared at the falling edge against a transfer-level reference model.
// Slave wait and master request patterns are driven from the bench.
module tb_bus_arbiter_id;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_Rst;
    logic          i_IBus_RdEn;
    logic [AW-1:0] i_IBus_Addr;
    logic [DW-1:0] o_IBus_RdData;
    logic          o_IBus_WaitReq;
    logic          i_DBus_RdEn;
    logic          i_DBus_WrEn;
    logic [AW-1:0] i_DBus_Addr;
    logic [DW-1:0] i_DBus_WrData;
    logic [BW-1:0] i_DBus_ByteEn;
    logic [DW-1:0] o_DBus_RdData;
    logic          o_DBus_WaitReq;
    logic          o_DBus_Gnt;
    logic [AW-1:0] o_Bus_Addr;
    logic          o_Bus_RdEn;
    logic          o_Bus_WrEn;
    logic [DW-1:0] o_Bus_WrData;
    logic [BW-1:0] o_Bus_ByteEn;
    logic [DW-1:0] i_Bus_RdData;
    logic          i_Bus_WaitReq;

    bus_arbiter_id #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
        .i_Clk          (clk),
        .i_Rst          (i_Rst),
        .i_IBus_RdEn    (i_IBus_RdEn),
        .i_IBus_Addr    (i_IBus_Addr),
        .o_IBus_RdData  (o_IBus_RdData),
        .o_IBus_WaitReq (o_IBus_WaitReq),
        .i_DBus_RdEn    (i_DBus_RdEn),
        .i_DBus_WrEn    (i_DBus_WrEn),
        .i_DBus_Addr    (i_DBus_Addr),
        .i_DBus_WrData  (i_DBus_WrData),
        .i_DBus_ByteEn  (i_DBus_ByteEn),
        .o_DBus_RdData  (o_DBus_RdData),
        .o_DBus_WaitReq (o_DBus_WaitReq),
        .o_DBus_Gnt     (o_DBus_Gnt),
        .o_Bus_Addr     (o_Bus_Addr),
        .o_Bus_RdEn     (o_Bus_RdEn),
        .o_Bus_WrEn     (o_Bus_WrEn),
        .o_Bus_WrData   (o_Bus_WrData),
        .o_Bus_ByteEn   (o_Bus_ByteEn),
        .i_Bus_RdData   (i_Bus_RdData),
        .i_Bus_WaitReq  (i_Bus_WaitReq)
    );

    int cmps = 0;
    int errs = 0;

    // Reference model: the transfer currently owning the port (0 none, 1 fetch, 2 data),
    // whether it is waiting for its read data, the latched command and the streak length.
    int            m_owner;
    bit            m_rsp;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    int            m_streak;
    logic [DW-1:0] m_ird;
    logic [DW-1:0] m_drd;

    bit            rec_en = 1'b0;
    bit            rec_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_rsp    = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_be     = '0;
        m_streak = 0;
        m_ird    = '0;
        m_drd    = '0;
    endtask

    // Compare all outputs against the model at the falling edge
    task automatic sample();
        bit strobing, idone, ddone, e_rd, e_wr, e_gnt, e_iw, e_dw;
        logic [DW-1:0] e_ird, e_drd;
        @(negedge clk);
        strobing = (m_owner != 0) && !m_rsp;
        e_rd  = strobing && !m_wr;
        e_wr  = strobing && m_wr;
        e_gnt = (m_owner == 2);
        ddone = (m_owner == 2) && ((strobing && m_wr && !i_Bus_WaitReq) || m_rsp);
        idone = (m_owner == 1) && m_rsp;
        e_iw  = i_IBus_RdEn && !idone;
        e_dw  = (i_DBus_RdEn || i_DBus_WrEn) && !ddone;
        e_ird = idone ? i_Bus_RdData : m_ird;
        e_drd = ((m_owner == 2) && m_rsp) ? i_Bus_RdData : m_drd;
        chk("strobes", {62'd0, o_Bus_RdEn, o_Bus_WrEn}, {62'd0, e_rd, e_wr});
        chk("gnt", {63'd0, o_DBus_Gnt}, {63'd0, e_gnt});
        chk("waitreq", {62'd0, o_IBus_WaitReq, o_DBus_WaitReq}, {62'd0, e_iw, e_dw});
        chk("rdata", {o_IBus_RdData, o_DBus_RdData}, {e_ird, e_drd});
        if (strobing) chk("cmd", {28'd0, o_Bus_Addr, o_Bus_ByteEn}, {28'd0, m_addr, m_be});
        if (e_wr) chk("wdata", {32'd0, o_Bus_WrData}, {32'd0, m_wdata});
        if (rec_en && (o_Bus_RdEn || o_Bus_WrEn)) rec_q.push_back(o_DBus_Gnt);
    endtask

    // Advance the model by one clock using the inputs present at the edge, then cross the edge
    task automatic advance();
        bit dreq, ireq;
        dreq = i_DBus_RdEn || i_DBus_WrEn;
        ireq = i_IBus_RdEn;
        if (i_Rst) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (dreq && !(ireq && m_streak == MAXS)) begin
                m_owner = 2;
                m_rsp   = 1'b0;
                m_wr    = i_DBus_WrEn;
                m_addr  = i_DBus_Addr;
                m_wdata = i_DBus_WrData;
                m_be    = i_DBus_ByteEn;
                if (ireq) begin
                    if (m_streak < 15) m_streak++;
                end else begin
                    m_streak = 0;
                end
            end else if (ireq) begin
                m_owner  = 1;
                m_rsp    = 1'b0;
                m_wr     = 1'b0;
                m_addr   = i_IBus_Addr;
                m_be     = '1;
                m_streak = 0;
            end
        end else if (!m_rsp) begin
            if (!i_Bus_WaitReq) begin
                if (m_wr) m_owner = 0;
                else m_rsp = 1'b1;
            end
        end else begin
            if (m_owner == 1) m_ird = i_Bus_RdData;
            else m_drd = i_Bus_RdData;
            m_owner = 0;
            m_rsp   = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        logic [9:0] exp_g;
        int         n_str;
        i_Rst = 1'b1;
        i_IBus_RdEn = 1'b1;
        i_IBus_Addr = '0;
        i_DBus_RdEn = 1'b0;
        i_DBus_WrEn = 1'b0;
        i_DBus_Addr = '0;
        i_DBus_WrData = '0;
        i_DBus_ByteEn = '0;
        i_Bus_RdData = '0;
        i_Bus_WaitReq = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state: fetch request visible as WaitReq, everything else quiet
        sample();
        chk("rst_waitreq", {62'd0, o_IBus_WaitReq, o_DBus_WaitReq}, 64'd2);
        chk("rst_outputs", {o_Bus_RdEn, o_Bus_WrEn, o_DBus_Gnt, o_Bus_Addr, o_Bus_ByteEn},
            {3'b000, 32'd0, 4'd0});
        advance();
        i_Rst = 1'b0;

        // Single fetch read, no slave wait
        i_IBus_Addr  = 32'h100;
        i_Bus_RdData = 32'hDEADBEEF;
        step();
        sample();
        chk("ird_cmd", {o_Bus_RdEn, o_Bus_WrEn, o_Bus_Addr, o_Bus_ByteEn, o_DBus_Gnt},
            {2'b10, 32'h100, 4'hF, 1'b0});
        advance();
        sample();
        chk("ird_done", {o_IBus_WaitReq, o_DBus_Gnt, o_IBus_RdData}, {2'b00, 32'hDEADBEEF});
        advance();
        i_IBus_RdEn = 1'b0;
        i_Bus_RdData = 32'h0BAD0BAD;
        sample();
        chk("ird_hold", {32'd0, o_IBus_RdData}, 64'hDEADBEEF);
        advance();

        // Data write with three slave wait cycles
        i_DBus_WrEn = 1'b1;
        i_DBus_Addr = 32'h200;
        i_DBus_WrData = 32'h12345678;
        i_DBus_ByteEn = 4'h3;
        step();
        i_Bus_WaitReq = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) i_Bus_WaitReq = 1'b0;
            sample();
            chk("dwr_hold", {o_Bus_WrEn, o_Bus_RdEn, o_DBus_Gnt, o_Bus_Addr, o_Bus_WrData, o_Bus_ByteEn},
                {3'b101, 32'h200, 32'h12345678, 4'h3});
            chk("dwr_wait", {63'd0, o_DBus_WaitReq}, (k == 3) ? 64'd0 : 64'd1);
            advance();
        end
        i_DBus_WrEn = 1'b0;
        step();

        // Both masters saturating: data streak capped at MAX_D_STREAK
        i_IBus_RdEn = 1'b1;
        i_IBus_Addr = 32'h400;
        i_DBus_WrEn = 1'b1;
        rec_q.delete();
        rec_en = 1'b1;
        for (int c = 0; c < 200 && rec_q.size() < 10; c++) begin
            step();
        end
        rec_en = 1'b0;
        chk("grant_count", rec_q.size(), 10);
        exp_g = 10'b1111011110;
        for (int i = 0; i < 10 && i < rec_q.size(); i++) begin
            chk("grant_order", {63'd0, rec_q[i]}, {63'd0, exp_g[9-i]});
        end
        i_IBus_RdEn = 1'b0;
        i_DBus_WrEn = 1'b0;
        repeat (3) step();

        // Back-to-back data reads with fetch idle: one read every three cycles
        i_DBus_RdEn = 1'b1;
        n_str = 0;
        for (int c = 0; c < 9; c++) begin
            i_Bus_RdData = $urandom;
            i_DBus_Addr = $urandom;
            sample();
            if (o_Bus_RdEn) n_str++;
            advance();
        end
        chk("b2b_reads", n_str, 3);
        i_DBus_RdEn = 1'b0;
        repeat (3) step();

        // Reset while a data command is stalled by the slave
        i_DBus_WrEn = 1'b1;
        i_Bus_WaitReq = 1'b1;
        step();
        sample();
        chk("rst_mid_gnt", {62'd0, o_DBus_Gnt, o_DBus_WaitReq}, 64'd3);
        i_Rst = 1'b1;
        advance();
        i_Rst = 1'b0;
        sample();
        chk("rst_mid_after", {61'd0, o_Bus_WrEn, o_Bus_RdEn, o_DBus_Gnt}, 64'd0);
        chk("rst_mid_wait", {63'd0, o_DBus_WaitReq}, 64'd1);
        advance();
        i_DBus_WrEn = 1'b0;
        i_Bus_WaitReq = 1'b0;
        repeat (3) step();

        // Read and write both asserted: a write is issued, no response phase
        i_DBus_RdEn = 1'b1;
        i_DBus_WrEn = 1'b1;
        i_DBus_Addr = 32'h300;
        step();
        sample();
        chk("rdwr_strobes", {62'd0, o_Bus_RdEn, o_Bus_WrEn}, 64'd1);
        advance();
        i_DBus_RdEn = 1'b0;
        i_DBus_WrEn = 1'b0;
        sample();
        chk("rdwr_no_rsp", {61'd0, o_Bus_RdEn, o_Bus_WrEn, o_DBus_Gnt}, 64'd0);
        advance();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            i_Rst         = ($urandom_range(0, 199) == 0);
            i_IBus_RdEn   = ($urandom_range(0, 1) == 1);
            i_IBus_Addr   = $urandom;
            i_DBus_RdEn   = ($urandom_range(0, 9) < 3);
            i_DBus_WrEn   = ($urandom_range(0, 9) < 3);
            i_DBus_Addr   = $urandom;
            i_DBus_WrData = $urandom;
            i_DBus_ByteEn = 4'($urandom);
            i_Bus_RdData  = $urandom;
            i_Bus_WaitReq = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
